// File: rtl/pe_pkg.sv
// Shared types for the PE unary/GEMM sequencer: op codes, FSM states, table depth.
// Imported by pe_coef_rf and pe_uno_seq.
package pe_pkg;

    typedef enum logic [1:0] {
        OP_GEMM = 2'b00,
        OP_DIV  = 2'b01,
        OP_EXP  = 2'b10,
        OP_LOG  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEMM,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int unsigned COEF_DEPTH = 8;
    localparam int unsigned N_BANKS    = 3;

endpackage

// File: rtl/pe_coef_rf.sv
// Coefficient/order register file: one bank per unary op (div/exp/log).
// Synchronous write, combinational read by (op, index); op 00 is not a bank.
module pe_coef_rf
    import pe_pkg::*;
#(
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned N_COEF = COEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic                      i_ord_we,
    input  op_e                       i_wop,
    input  logic [$clog2(N_COEF)-1:0] i_waddr,
    input  logic [MUL_BW-1:0]         i_wdata,
    input  op_e                       i_rop,
    input  logic [$clog2(N_COEF)-1:0] i_ridx,
    output logic [MUL_BW-1:0]         o_rdata,
    output logic [$clog2(N_COEF):0]   o_rord
);

    localparam int unsigned AW = $clog2(N_COEF);
    localparam logic [AW:0] ORD_MIN = (AW+1)'(1);
    localparam logic [AW:0] ORD_MAX = (AW+1)'(N_COEF);

    logic [MUL_BW-1:0] r_coef [N_BANKS][N_COEF];
    logic [AW:0]       r_ord  [N_BANKS];
    logic [1:0]        w_wbank;
    logic [1:0]        w_rbank;
    logic [AW:0]       w_ord_wr;

    assign w_wbank = 2'(i_wop) - 2'd1;
    assign w_rbank = 2'(i_rop) - 2'd1;

    // Orders outside 1..N_COEF are clamped so Horner always issues at least one step.
    always_comb begin
        w_ord_wr = i_wdata[AW:0];
        if (w_ord_wr == '0) begin
            w_ord_wr = ORD_MIN;
        end else if (w_ord_wr > ORD_MAX) begin
            w_ord_wr = ORD_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < N_BANKS; b++) begin
                r_ord[b] <= ORD_MIN;
                for (int unsigned i = 0; i < N_COEF; i++) begin
                    r_coef[b][i] <= '0;
                end
            end
        end else if (i_wop != OP_GEMM) begin
            if (i_we) begin
                r_coef[w_wbank][i_waddr] <= i_wdata;
            end
            if (i_ord_we) begin
                r_ord[w_wbank] <= w_ord_wr;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        o_rord  = ORD_MIN;
        if (i_rop != OP_GEMM) begin
            o_rdata = r_coef[w_rbank][i_ridx];
            o_rord  = r_ord[w_rbank];
        end
    end

endmodule

// File: rtl/pe_uno_seq.sv
// Row-0 PE sequencer: Horner evaluation of div/exp/log over coefficient tables
// (highest coefficient first) and framing of fixed-length GEMM passes.
module pe_uno_seq
    import pe_pkg::*;
#(
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned ACC_BW = 32,
    parameter int unsigned N_COEF = COEF_DEPTH,
    parameter int unsigned LEN_BW = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [1:0]                op_i,
    input  logic [MUL_BW-1:0]         x_i,
    input  logic [LEN_BW-1:0]         gemm_len_i,
    input  logic                      cfg_we_i,
    input  logic [1:0]                cfg_op_i,
    input  logic [$clog2(N_COEF)-1:0] cfg_addr_i,
    input  logic [MUL_BW-1:0]         cfg_data_i,
    input  logic                      cfg_ord_we_i,
    input  logic [ACC_BW-1:0]         res_i,
    output logic                      busy_o,
    output logic [1:0]                gemm_uno_o,
    output logic [MUL_BW-1:0]         wc_o,
    output logic [MUL_BW-1:0]         var_o,
    output logic                      mac_zero_o,
    output logic [ACC_BW-1:0]         y_o,
    output logic                      done_o
);

    localparam int unsigned AW = $clog2(N_COEF);
    localparam int unsigned KW = AW + 1;

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    op_e               w_rd_op;
    logic [LEN_BW-1:0] r_len;
    logic [LEN_BW-1:0] r_cnt;
    logic [KW-1:0]     r_k;
    logic [KW-1:0]     w_rd_ord;
    logic [AW-1:0]     w_rd_idx;
    logic [MUL_BW-1:0] w_rd_coef;
    logic              w_issue_last;

    // In IDLE the table is addressed by the incoming op so the top coefficient is
    // ready at acceptance; in ISSUE it pre-fetches the coefficient for step k+1.
    assign w_rd_op      = (r_state == ST_IDLE) ? op_e'(op_i) : r_op;
    assign w_rd_idx     = (r_state == ST_IDLE) ? AW'(w_rd_ord - KW'(1))
                                               : AW'(w_rd_ord - r_k - KW'(2));
    assign w_issue_last = (r_k == w_rd_ord - KW'(1));

    pe_coef_rf #(
        .MUL_BW (MUL_BW),
        .N_COEF (N_COEF)
    ) u_coef_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (cfg_we_i && !busy_o),
        .i_ord_we (cfg_ord_we_i && !busy_o),
        .i_wop    (op_e'(cfg_op_i)),
        .i_waddr  (cfg_addr_i),
        .i_wdata  (cfg_data_i),
        .i_rop    (w_rd_op),
        .i_ridx   (w_rd_idx),
        .o_rdata  (w_rd_coef),
        .o_rord   (w_rd_ord)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (op_e'(op_i) != OP_GEMM) begin
                        w_state_nxt = ST_ISSUE;
                    end else if (gemm_len_i == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_GEMM;
                    end
                end
            end
            ST_GEMM:  if (r_cnt == r_len) w_state_nxt = ST_DONE;
            ST_ISSUE: if (w_issue_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_k == KW'(1)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_GEMM;
            r_len      <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            busy_o     <= 1'b0;
            gemm_uno_o <= '0;
            wc_o       <= '0;
            var_o      <= '0;
            mac_zero_o <= 1'b0;
            y_o        <= '0;
            done_o     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            busy_o     <= w_state_nxt inside {ST_GEMM, ST_ISSUE, ST_DRAIN};
            done_o     <= (w_state_nxt == ST_DONE);
            // High for exactly the cycle in which the PE consumes the first coefficient.
            mac_zero_o <= (r_state == ST_ISSUE) && (r_k == '0);
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_op  <= op_e'(op_i);
                        r_len <= gemm_len_i;
                        r_cnt <= '0;
                        r_k   <= '0;
                        gemm_uno_o <= op_i;
                        if (op_e'(op_i) != OP_GEMM) begin
                            var_o <= x_i;
                            wc_o  <= w_rd_coef;
                        end
                    end
                end
                ST_GEMM: r_cnt <= r_cnt + LEN_BW'(1);
                ST_ISSUE: begin
                    if (w_issue_last) begin
                        r_k  <= '0;
                        wc_o <= '0;
                    end else begin
                        r_k  <= r_k + KW'(1);
                        wc_o <= w_rd_coef;
                    end
                end
                ST_DRAIN: begin
                    r_k <= r_k + KW'(1);
                    if (w_state_nxt == ST_DONE) begin
                        y_o <= res_i;
                    end
                end
                ST_DONE: gemm_uno_o <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_uno_seq.sv
// Bench for pe_uno_seq with a behavioural 2-stage PE; expected results and
// latencies are queued at start and checked when done_o fires.
module tb_pe_uno_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [15:0] x_i = '0;
    logic [15:0] gemm_len_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_op_i = '0;
    logic [2:0]  cfg_addr_i = '0;
    logic [15:0] cfg_data_i = '0;
    logic        cfg_ord_we_i = 1'b0;
    logic [31:0] res_i;
    logic        busy_o;
    logic [1:0]  gemm_uno_o;
    logic [15:0] wc_o;
    logic [15:0] var_o;
    logic        mac_zero_o;
    logic [31:0] y_o;
    logic        done_o;

    pe_uno_seq #(
        .MUL_BW (16),
        .ACC_BW (32),
        .N_COEF (8),
        .LEN_BW (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .op_i         (op_i),
        .x_i          (x_i),
        .gemm_len_i   (gemm_len_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_op_i     (cfg_op_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_ord_we_i (cfg_ord_we_i),
        .res_i        (res_i),
        .busy_o       (busy_o),
        .gemm_uno_o   (gemm_uno_o),
        .wc_o         (wc_o),
        .var_o        (var_o),
        .mac_zero_o   (mac_zero_o),
        .y_o          (y_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t_acc;
        int unsigned lat;
        logic [31:0] y;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    logic [15:0] tb_coef [4][8];
    int unsigned tb_ord [4];
    logic [31:0] y_model;
    logic [15:0] pe_wc;
    logic [15:0] pe_var;
    logic [31:0] pe_res;

    // Behavioural PE: input register stage, then accumulate stage (2-cycle latency).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_wc  <= '0;
            pe_var <= '0;
            pe_res <= '0;
        end else begin
            pe_wc  <= wc_o;
            pe_var <= var_o;
            pe_res <= 32'(pe_wc) + 32'(pe_var) * (mac_zero_o ? 32'd0 : pe_res);
        end
    end
    assign res_i = pe_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done_o, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - e.t_acc, e.lat);
                    chk("y", y_o, e.y);
                end
            end
        end
    end

    function automatic logic [31:0] horner(input int unsigned op, input logic [15:0] x);
        logic [31:0] a;
        a = '0;
        for (int i = int'(tb_ord[op]) - 1; i >= 0; i--) begin
            a = 32'(tb_coef[op][i]) + 32'(x) * a;
        end
        return a;
    endfunction

    task automatic model_reset();
        for (int unsigned o = 0; o < 4; o++) begin
            tb_ord[o] = 1;
            for (int unsigned i = 0; i < 8; i++) tb_coef[o][i] = '0;
        end
        y_model = '0;
    endtask

    task automatic cfg_wr(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we_i = 1'b1; cfg_op_i = op; cfg_addr_i = a; cfg_data_i = d;
        @(negedge clk);
        cfg_we_i = 1'b0;
        if (op != 2'b00) tb_coef[op][a] = d;
    endtask

    task automatic ord_wr(input logic [1:0] op, input logic [15:0] d);
        int unsigned v;
        @(negedge clk);
        cfg_ord_we_i = 1'b1; cfg_op_i = op; cfg_data_i = d;
        @(negedge clk);
        cfg_ord_we_i = 1'b0;
        v = int'(d[3:0]);
        if (op != 2'b00) tb_ord[op] = (v == 0) ? 1 : (v > 8) ? 8 : v;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] x,
                          input logic [15:0] len, input bit disturb);
        int unsigned ord, lat, n_mz, n_busy;
        logic [31:0] y_exp;
        ord = (op == 2'b00) ? 0 : tb_ord[op];
        if (op == 2'b00) begin
            lat   = (len == 0) ? 0 : int'(len) + 1;
            y_exp = y_model;
        end else begin
            lat   = ord + 2;
            y_exp = horner(int'(op), x);
        end
        @(negedge clk);
        start_i = 1'b1; op_i = op; x_i = x; gemm_len_i = len;
        sb.push_back('{t_acc: cyc + 1, lat: lat, y: y_exp});
        y_model = y_exp;
        @(negedge clk);
        start_i = 1'b0;
        n_mz = 0;
        n_busy = 0;
        for (int unsigned c = 0; c < 200 && sb.size() != 0; c++) begin
            if (op != 2'b00 && c == 0) chk("var", var_o, x);
            if (op != 2'b00 && c < ord) chk("wc_step", wc_o, tb_coef[op][ord-1-c]);
            if (op != 2'b00 && c == ord) chk("wc_drain", wc_o, 0);
            if (busy_o) begin
                n_busy++;
                chk("mode", gemm_uno_o, op);
            end
            if (mac_zero_o) n_mz++;
            if (disturb && c == 1) begin
                start_i = 1'b1; op_i = 2'b01; gemm_len_i = '0;
                cfg_we_i = 1'b1; cfg_op_i = op; cfg_addr_i = '0; cfg_data_i = 16'hdead;
            end else begin
                start_i = 1'b0; cfg_we_i = 1'b0;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        cfg_we_i = 1'b0;
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        chk("mac_zero_cycles", n_mz, (op != 2'b00) ? 1 : 0);
        chk("busy_cycles", n_busy, lat);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_y", y_o, 0);
        chk("rst_wc", wc_o, 0);
        chk("rst_var", var_o, 0);
        chk("rst_mode", gemm_uno_o, 0);
        chk("rst_mz", mac_zero_o, 0);
        rst_n = 1'b1;

        // exp table from the reference case
        cfg_wr(2'b10, 3'd0, 16'h0040);
        cfg_wr(2'b10, 3'd1, 16'h0040);
        cfg_wr(2'b10, 3'd2, 16'h0020);
        ord_wr(2'b10, 16'd3);
        run_op(2'b10, 16'h0040, '0, 1'b0);
        chk("exp_ref_y", y_o, 32'h0002_1040);

        run_op(2'b00, '0, 16'd4, 1'b0);
        chk("gemm_y_held", y_o, 32'h0002_1040);
        run_op(2'b00, '0, 16'd0, 1'b0);

        // start and cfg write during ISSUE must both be ignored
        run_op(2'b10, 16'h0003, '0, 1'b1);
        run_op(2'b10, 16'h0005, '0, 1'b0);

        // order clamping on the div table
        ord_wr(2'b01, 16'd0);
        cfg_wr(2'b01, 3'd0, 16'h0007);
        run_op(2'b01, 16'h0100, '0, 1'b0);
        ord_wr(2'b01, 16'd15);
        for (int unsigned i = 0; i < 8; i++) cfg_wr(2'b01, 3'(i), 16'(i * 3 + 1));
        run_op(2'b01, 16'h0002, '0, 1'b0);

        // cfg_op 00 write has no effect; log table with random contents
        cfg_wr(2'b00, 3'd0, 16'hffff);
        ord_wr(2'b00, 16'd2);
        for (int unsigned i = 0; i < 4; i++) cfg_wr(2'b11, 3'(i), 16'($urandom_range(0, 255)));
        ord_wr(2'b11, 16'd4);
        run_op(2'b11, 16'($urandom_range(1, 300)), '0, 1'b0);
        run_op(2'b00, '0, 16'd2, 1'b0);

        // reset in the middle of ISSUE
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b10; x_i = 16'h0011; gemm_len_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_wc", wc_o, 0);
        chk("mid_rst_var", var_o, 0);
        chk("mid_rst_mode", gemm_uno_o, 0);
        chk("mid_rst_y", y_o, 0);
        chk("mid_rst_mz", mac_zero_o, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("mid_rst_done", done_o, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", busy_o, 0);

        // tables back at reset contents, then normal operation
        run_op(2'b10, 16'h0011, '0, 1'b0);
        cfg_wr(2'b10, 3'd0, 16'h0001);
        cfg_wr(2'b10, 3'd1, 16'h0002);
        ord_wr(2'b10, 16'd2);
        run_op(2'b10, 16'h0010, '0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
